// File: rtl/dp_sequencer.sv
// Sequencer for the pair-combine datapath.
// Loads DEPTH_A operands into RAM A through a valid/ready handshake, then walks
// RAM A in even/odd pairs so that each pair's combined result lands in RAM B.
// A single-cycle done pulse marks the end of a run.
module dp_sequencer #(
    parameter int unsigned DEPTH_A = 8,
    parameter int unsigned AW_A    = 3,
    parameter int unsigned DEPTH_B = 4,
    parameter int unsigned AW_B    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            wea,
    output logic [AW_A-1:0] adda,
    output logic            web,
    output logic [AW_B-1:0] addb,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StEven = 3'd2;
    localparam logic [2:0] StOdd  = 3'd3;
    localparam logic [2:0] StFin  = 3'd4;

    localparam logic [AW_A-1:0] AddaLast = AW_A'(DEPTH_A - 1);
    localparam logic [AW_B-1:0] AddbLast = AW_B'(DEPTH_B - 1);
    localparam logic [AW_A-1:0] AddaOne  = AW_A'(1);
    localparam logic [AW_B-1:0] AddbOne  = AW_B'(1);

    logic [2:0]      state_q, state_d;
    logic [AW_A-1:0] adda_q, adda_d;
    logic [AW_B-1:0] addb_q, addb_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state and address sequencing.
    always_comb begin
        state_d = state_q;
        adda_d  = adda_q;
        addb_d  = addb_q;
        case (state_q)
            StIdle: begin
                adda_d = '0;
                addb_d = '0;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // A stalled handshake simply holds the write address.
                if (in_valid) begin
                    if (adda_q == AddaLast) begin
                        adda_d  = '0;
                        state_d = StEven;
                    end else begin
                        adda_d = adda_q + AddaOne;
                    end
                end
            end
            StEven: begin
                adda_d  = adda_q + AddaOne;
                state_d = StOdd;
            end
            StOdd: begin
                if (addb_q == AddbLast) begin
                    adda_d  = '0;
                    addb_d  = '0;
                    state_d = StFin;
                end else begin
                    adda_d  = adda_q + AddaOne;
                    addb_d  = addb_q + AddbOne;
                    state_d = StEven;
                end
            end
            StFin: begin
                adda_d  = '0;
                addb_d  = '0;
                state_d = StIdle;
            end
            default: begin
                adda_d  = '0;
                addb_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Registered status flags follow the state being entered.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_d == StFin);
    end

    // State and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            adda_q  <= '0;
            addb_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adda_q  <= adda_d;
            addb_q  <= addb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Handshake and write strobes decode from the registered state only.
    always_comb begin
        in_ready = (state_q == StLoad);
        wea      = in_ready & in_valid;
        web      = (state_q == StOdd);
    end

    assign adda = adda_q;
    assign addb = addb_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: drives random and directed runs, models the RAMs and
// combine datapath around the DUT, and checks every cycle against a run model.
module tb_dp_sequencer;

    localparam int DEPTH_A = 8;
    localparam int AW_A    = 3;
    localparam int DEPTH_B = 4;
    localparam int AW_B    = 2;

    localparam int MIdle = 0;
    localparam int MLoad = 1;
    localparam int MComp = 2;
    localparam int MFin  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = 8'd0;
    logic            in_ready, wea, web, busy, done;
    logic [AW_A-1:0] adda;
    logic [AW_B-1:0] addb;

    dp_sequencer #(
        .DEPTH_A(DEPTH_A),
        .AW_A   (AW_A),
        .DEPTH_B(DEPTH_B),
        .AW_B   (AW_B)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wea     (wea),
        .adda    (adda),
        .web     (web),
        .addb    (addb),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Combine rule: subtract when the even operand is not smaller, else add.
    function automatic logic [7:0] combine(input logic [7:0] p, input logic [7:0] a);
        return (p >= a) ? p - a : p + a;
    endfunction

    // Datapath around the sequencer: RAM A, pipeline register, RAM B.
    logic [7:0] ram_a [DEPTH_A];
    logic [7:0] ram_b [DEPTH_B];
    logic [7:0] pipe;
    always @(posedge clk) begin
        if (wea) ram_a[adda] <= in_data;
        pipe <= ram_a[adda];
        if (web) ram_b[addb] <= combine(pipe, ram_a[adda]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Run model: phase, words accepted, compute step, plus bookkeeping.
    int         m_mode = MIdle;
    int         m_cnt = 0;
    int         m_step = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    int         lat = 0;
    int         n_done_total = 0;
    logic [7:0] next_data [DEPTH_A];
    logic [7:0] cur_data [DEPTH_A];

    task automatic model_edge();
        cyc++;
        if (!reset) begin
            m_mode = MIdle;
            return;
        end
        case (m_mode)
            MIdle: if (start) begin
                m_mode    = MLoad;
                m_cnt     = 0;
                cur_data  = next_data;
                start_cyc = cyc;
            end
            MLoad: if (in_valid) begin
                m_cnt++;
                if (m_cnt == DEPTH_A) begin
                    m_mode = MComp;
                    m_step = 0;
                end
            end
            MComp: begin
                m_step++;
                if (m_step == 2 * DEPTH_B) m_mode = MFin;
            end
            default: m_mode = MIdle;
        endcase
    endtask

    // Drive one cycle of inputs, then advance across the next rising edge.
    task automatic cycle(input logic s, input logic v);
        start    = s;
        in_valid = v;
        in_data  = (m_mode == MLoad) ? cur_data[m_cnt] : 8'($urandom);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_until_idle(input int vpct, input int spct, input int budget);
        int n = 0;
        do begin
            cycle(int'($urandom_range(99)) < spct, int'($urandom_range(99)) < vpct);
            n++;
        end while (m_mode != MIdle && n < budget);
        chk("run_end_idle", m_mode, MIdle);
    endtask

    task automatic rand_data();
        for (int i = 0; i < DEPTH_A; i++) next_data[i] = 8'($urandom);
    endtask

    // Per-cycle comparison of every DUT output against the run model.
    initial begin
        int   prev_mode = MIdle;
        logic prev_done = 1'b0;
        int   n_wea = 0;
        int   n_web = 0;
        forever begin
            @(negedge clk);
            if (m_mode == MLoad && prev_mode != MLoad) begin
                n_wea = 0;
                n_web = 0;
            end
            chk("in_ready", in_ready, m_mode == MLoad);
            chk("wea", wea, m_mode == MLoad && in_valid);
            chk("web", web, m_mode == MComp && (m_step % 2) == 1);
            chk("adda", adda, (m_mode == MLoad) ? m_cnt : (m_mode == MComp) ? m_step : 0);
            chk("addb", addb, (m_mode == MComp) ? m_step / 2 : 0);
            chk("busy", busy, m_mode != MIdle);
            chk("done", done, m_mode == MFin);
            chk("wea_web_excl", wea && web, 0);
            if (web) chk("web_odd_adda", adda[0], 1);
            chk("done_twice", done && prev_done, 0);
            if (wea) n_wea++;
            if (web) n_web++;
            if (done) begin
                n_done_total++;
                done_cyc = cyc;
                lat      = cyc - start_cyc + 1;
                chk("wea_count", n_wea, DEPTH_A);
                chk("web_count", n_web, DEPTH_B);
                for (int i = 0; i < DEPTH_B; i++)
                    chk("ram_b", ram_b[i], combine(cur_data[2*i], cur_data[2*i+1]));
            end
            prev_done = done;
            prev_mode = m_mode;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int i;
        // Reset state while reset is held.
        #2;
        chk("rst_adda", adda, 0);
        chk("rst_addb", addb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wea", wea, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cycle(0, 0);

        // Nominal run with hand-computed results.
        next_data = '{8'd10, 8'd3, 8'd5, 8'd9, 8'd200, 8'd100, 8'd7, 8'd7};
        cycle(1, 0);
        run_until_idle(100, 0, 100);
        chk("nom_lat", lat, 17);
        chk("nom_rb0", ram_b[0], 7);
        chk("nom_rb1", ram_b[1], 14);
        chk("nom_rb2", ram_b[2], 100);
        chk("nom_rb3", ram_b[3], 0);
        cycle(0, 0);

        // Stalled load: valid on every third cycle.
        rand_data();
        cycle(1, 0);
        i = 0;
        do begin
            cycle(0, (i % 3) == 0);
            i++;
        end while (m_mode != MIdle && i < 100);
        chk("stall_end_idle", m_mode, MIdle);
        chk("stall_lat", lat, 31);

        // start pulsed during LOAD and during ODD must be ignored.
        rand_data();
        d0 = n_done_total;
        cycle(1, 0);
        i = 0;
        do begin
            cycle((m_mode == MLoad && m_cnt < 2) || (m_mode == MComp && (m_step % 2) == 1), 1);
            i++;
        end while (m_mode != MIdle && i < 100);
        chk("busy_start_lat", lat, 17);
        repeat (3) cycle(0, 1);
        chk("single_done", n_done_total - d0, 1);

        // Back-to-back runs with start held high.
        rand_data();
        cycle(1, 0);
        run_until_idle(100, 100, 100);
        next_data = '{8'd1, 8'd2, 8'd50, 8'd40, 8'd0, 8'd255, 8'd128, 8'd128};
        cycle(1, 1);
        chk("b2b_gap", start_cyc - done_cyc, 2);
        run_until_idle(100, 100, 100);
        chk("b2b_rb0", ram_b[0], 3);
        chk("b2b_rb1", ram_b[1], 10);
        chk("b2b_rb2", ram_b[2], 255);
        chk("b2b_rb3", ram_b[3], 0);
        cycle(0, 0);

        // Reset mid-LOAD after three accepted words.
        rand_data();
        cycle(1, 0);
        repeat (3) cycle(0, 1);
        #1;
        reset  = 1'b0;
        m_mode = MIdle;
        #1;
        chk("mid_rst_wea", wea, 0);
        chk("mid_rst_web", web, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_adda", adda, 0);
        chk("mid_rst_ready", in_ready, 0);
        cycle(0, 1);
        reset = 1'b1;
        repeat (4) cycle(0, 1);

        // Randomised runs with random stalls, gaps and stray start pulses.
        repeat (10) begin
            rand_data();
            repeat ($urandom_range(3)) cycle(0, $urandom_range(1));
            cycle(1, $urandom_range(1));
            run_until_idle(int'($urandom_range(30, 100)), 30, 400);
        end
        repeat (3) cycle(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
